// File: rtl/fetch_loader.sv
// Instruction memory loader and fetch unit: fills a word-addressed instruction RAM
// from a valid/ready stream, then serves registered fetches by byte-addressed pc.
module fetch_loader #(
   parameter int unsigned      INST_SIZE  = 12,
   parameter int unsigned      WIDTH      = 32,
   parameter logic [WIDTH-1:0] RESET_INST = '0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [2:0]           mode,
   input  logic [INST_SIZE:0]   load_len,
   input  logic [WIDTH-1:0]     s_data,
   input  logic                 s_valid,
   output logic                 s_ready,
   input  logic [31:0]          pc,
   output logic [WIDTH-1:0]     inst,
   output logic                 inst_valid,
   output logic                 pc_err,
   output logic                 done,
   output logic [INST_SIZE:0]   load_cnt
);

   localparam int unsigned        DEPTH     = 1 << INST_SIZE;
   localparam logic [2:0]         MODE_LOAD = 3'd1;
   localparam logic [2:0]         MODE_EXEC = 3'd2;
   localparam logic [INST_SIZE:0] CNT_ONE   = (INST_SIZE+1)'(1);
   localparam logic [INST_SIZE-1:0] ADDR_ONE = INST_SIZE'(1);

   typedef enum logic [1:0] {IDLE, LOADING, LOADED} state_t;

   state_t               state;
   logic [INST_SIZE:0]   len_q;
   logic [INST_SIZE-1:0] wr_addr;
   logic [WIDTH-1:0]     mem [DEPTH];

   logic                 accept;
   logic                 last_word;
   logic                 pc_bad;
   logic [INST_SIZE-1:0] rd_idx;

   assign s_ready   = (state == LOADING) && (mode == MODE_LOAD);
   assign accept    = s_ready && s_valid;
   assign last_word = (load_cnt + CNT_ONE) == len_q;
   assign rd_idx    = pc[INST_SIZE+1:2];
   assign pc_bad    = (|pc[1:0]) || (|pc[31:INST_SIZE+2]);

   // Memory has no reset so contents survive rst and map onto distributed RAM.
   always_ff @(posedge clk) begin
      if (accept) mem[wr_addr] <= s_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         len_q      <= '0;
         wr_addr    <= '0;
         load_cnt   <= '0;
         done       <= 1'b0;
         inst       <= RESET_INST;
         inst_valid <= 1'b0;
         pc_err     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (mode == MODE_LOAD) begin
                  len_q    <= load_len;
                  wr_addr  <= '0;
                  load_cnt <= '0;
                  if (load_len == '0) begin
                     state <= LOADED;
                     done  <= 1'b1;
                  end else begin
                     state <= LOADING;
                  end
               end
            end
            LOADING: begin
               if (accept) begin
                  load_cnt <= load_cnt + CNT_ONE;
                  // Hold the address on the final word so a full-depth load never wraps to 0.
                  if (last_word) begin
                     state <= LOADED;
                     done  <= 1'b1;
                  end else begin
                     wr_addr <= wr_addr + ADDR_ONE;
                  end
               end
            end
            LOADED: ;
            default: state <= IDLE;
         endcase

         if (mode == MODE_EXEC) begin
            if (!done) begin
               inst       <= RESET_INST;
               inst_valid <= 1'b0;
               pc_err     <= 1'b0;
            end else if (pc_bad) begin
               inst       <= RESET_INST;
               inst_valid <= 1'b0;
               pc_err     <= 1'b1;
            end else begin
               inst       <= mem[rd_idx];
               inst_valid <= 1'b1;
               pc_err     <= 1'b0;
            end
         end
      end
   end

endmodule

// File: doc/fetch_loader.md
FETCH_LOADER -- requirements
Module: fetch_loader

Interface
REQ-001 Parameter INST_SIZE, default 12; log2 of instruction memory depth in words (depth 4096).
REQ-002 Parameter WIDTH, default 32; instruction word width in bits.
REQ-003 Parameter RESET_INST, default 32'h0000_0000; value driven on inst when no valid instruction is presented.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 mode  input  3  0=STALL, 1=LOAD, 2=EXEC; values 3-7 treated as STALL.
REQ-007 load_len  input  INST_SIZE+1  number of words to load; sampled on LOAD entry; range 0..2^INST_SIZE.
REQ-008 s_data  input  WIDTH  load-stream word.
REQ-009 s_valid  input  1  s_data valid.
REQ-010 s_ready  output  1  loader accepts s_data this cycle.
REQ-011 pc  input  32  byte address of instruction to fetch.
REQ-012 inst  output  WIDTH  registered fetched instruction.
REQ-013 inst_valid  output  1  inst holds a legal fetched word.
REQ-014 pc_err  output  1  last EXEC fetch used a misaligned or out-of-range pc.
REQ-015 done  output  1  load complete; sticky until rst.
REQ-016 load_cnt  output  INST_SIZE+1  words written so far.

Function
REQ-017 FSM states SHALL be IDLE, LOADING, LOADED; reset state IDLE.
REQ-018 IDLE, mode==LOAD: latch load_len, clear write address; go to LOADING, or to LOADED with done=1 next cycle if load_len==0.
REQ-019 IDLE, any other mode: remain IDLE; s_ready=0.
REQ-020 s_ready SHALL equal (state==LOADING && mode==LOAD), combinational from registered state and mode.
REQ-021 Handshake: word accepted only on a cycle with s_valid && s_ready; mem[wr_addr] <= s_data, wr_addr and load_cnt increment by 1.
REQ-022 LOADING with mode!=LOAD: pause; s_ready=0, wr_addr and load_cnt held; resume when mode returns to LOAD.
REQ-023 Acceptance making load_cnt equal the latched length: go to LOADED, done=1 on the following cycle; no further words accepted.
REQ-024 load_len==2^INST_SIZE: last write lands at address 2^INST_SIZE-1; wr_addr SHALL NOT wrap to overwrite address 0.
REQ-025 LOADED: s_ready=0 in all modes; further LOAD requests ignored; leaving LOADED requires rst.
REQ-026 Fetch index SHALL be pc[INST_SIZE+1:2].
REQ-027 pc illegal when pc[1:0]!=0 or pc[31:INST_SIZE+2]!=0.
REQ-028 mode==EXEC && done, legal pc: next cycle inst=mem[index], inst_valid=1, pc_err=0 (one-cycle latency).
REQ-029 mode==EXEC && done, illegal pc: next cycle inst=RESET_INST, inst_valid=0, pc_err=1.
REQ-030 mode==EXEC && !done: next cycle inst=RESET_INST, inst_valid=0, pc_err=0.
REQ-031 mode STALL or LOAD (and 3-7): inst, inst_valid, pc_err hold their previous values.
REQ-032 Locations at or beyond the latched length are never written; fetches from them are undefined data with inst_valid=1.
REQ-033 Memory contents SHALL NOT be cleared by reset; memory is inferred as distributed RAM, one write port, one read port.

Reset
REQ-034 rst asserted: immediately state=IDLE, done=0, load_cnt=0, wr_addr=0, inst=RESET_INST, inst_valid=0, pc_err=0, s_ready=0.
REQ-035 rst mid-LOADING: load aborted, partial count discarded; a later LOAD restarts at address 0.
REQ-036 Operation resumes on the first rising clk edge after rst deasserts.

Verification
REQ-037 load_len=4, mode=LOAD, s_valid every cycle, data 0xA0..0xA3 -> load_cnt 1..4 on successive cycles, done=1 the cycle after 4th accept; EXEC pc=0x8 -> inst=0xA2, inst_valid=1 one cycle later.
REQ-038 load_len=3, s_valid toggled 1,0,1,0,1 and mode=STALL for 2 cycles mid-load -> exactly 3 words stored, s_ready=0 while STALL, done only after 3rd accept.
REQ-039 done=1, EXEC pc=0x6 -> inst=RESET_INST, inst_valid=0, pc_err=1; next pc=0x4 -> pc_err=0, inst_valid=1.
REQ-040 INST_SIZE=4, EXEC pc=0x40 -> pc_err=1; pc=0x3C -> inst=mem[15].
REQ-041 load_len=16 (INST_SIZE=4), full load -> mem[0] unchanged after 16th write, done=1, extra s_valid ignored (s_ready=0).
REQ-042 rst pulse after 2 of 5 words -> all outputs at reset values within the reset cycle; new LOAD with load_len=1, data 0x55 -> mem[0]=0x55, done=1.
